color_poll_seq: RTL and testbench
=================================

COLOR_POLL_SEQ -- requirements
Module: color_poll_seq

Interface
REQ-001 SHALL have parameter INIT_N_G, default 2: number of ROM init-write entries issued after start.
REQ-002 SHALL have parameter CH_G, default 3: colour channels read per sample, legal 1..4.
REQ-003 SHALL have parameter CH_W_G, default 16: bits per channel, legal 8 or 16; CH_G*CH_W_G/8 SHALL NOT exceed 8.
REQ-004 SHALL have parameter STALL_G, default 240000: settle cycles between init and first read.
REQ-005 SHALL have parameter PERIOD_G, default 1000000: cycles between consecutive read starts in continuous mode.
REQ-006 SHALL have parameter TMO_G, default 4000000: max cycles any I2C transaction may take.
REQ-007 SHALL have parameter CMD_G, default 16'hB4A0: 2-byte register-select command sent before every read.
REQ-008 SHALL have ports clk_i in 1 (single clock) and rst_i in 1 (reset, synchronous, active-high).
REQ-009 SHALL have ports start_i in 1 (level, run request), cont_i in 1 (1 = continuous polling, 0 = single shot).
REQ-010 SHALL have ports i2c_send_o out 1, i2c_nbytes_o out 4, i2c_data_o out 72, i2c_data_i in 72, i2c_done_i in 1, i2c_ready_i in 1 (I2C master handshake).
REQ-011 SHALL have ports rom_addr_o out $clog2(INIT_N_G+1), rom_data_i in 32 (init ROM, 1-cycle read latency).
REQ-012 SHALL have ports sample_o out CH_G*CH_W_G, sample_valid_o out 1, sample_cnt_o out 16, busy_o out 1, init_done_o out 1, err_o out 1.

Function
REQ-013 SHALL implement states IDLE, FETCH, ISEND, IWAIT, STALL, CSEND, CWAIT, RSEND, RWAIT, PUBLISH, PERIOD, HOLD, ERR.
REQ-014 IDLE->FETCH on start_i=1 with rom_addr_o=0; if INIT_N_G=0 or init_done_o=1, IDLE->CSEND directly.
REQ-015 FETCH lasts one cycle (ROM latency); ->ISEND.
REQ-016 ISEND: one-cycle i2c_send_o=1, i2c_nbytes_o=rom_data_i[31:28], i2c_data_o={48'd0,rom_data_i[23:0]}; ->IWAIT.
REQ-017 IWAIT on i2c_done_i: rom_addr_o++; if rom_addr_o<INIT_N_G-1 ->FETCH, else set init_done_o=1 ->STALL.
REQ-018 STALL counts exactly STALL_G cycles, then ->CSEND.
REQ-019 CSEND: one-cycle send, nbytes=2, i2c_data_o={56'd0,CMD_G}; ->CWAIT; on done ->RSEND.
REQ-020 RSEND: one-cycle send, nbytes=CH_G*CH_W_G/8, i2c_data_o=0; ->RWAIT; on done ->PUBLISH.
REQ-021 PUBLISH: sample_o<=i2c_data_i[CH_G*CH_W_G-1:0] (channel k at bits [k*CH_W_G +: CH_W_G]), sample_valid_o=1 that cycle only, sample_cnt_o++ wrapping 16'hFFFF->0.
REQ-022 PUBLISH ->PERIOD if cont_i=1 and start_i=1, else ->HOLD.
REQ-023 PERIOD: next CSEND SHALL occur exactly PERIOD_G cycles after the previous CSEND; if read took >=PERIOD_G cycles, ->CSEND immediately.
REQ-024 i2c_send_o SHALL assert only when i2c_ready_i=1; a SEND state waits with send low while ready is low.
REQ-025 Every WAIT state counts cycles; reaching TMO_G without i2c_done_i ->ERR; err_o=1, sample_o unchanged.
REQ-026 ERR and HOLD ->IDLE when start_i=0; err_o clears on leaving ERR.
REQ-027 start_i=0 in PERIOD ->IDLE; in any other state the current transaction completes first.
REQ-028 busy_o=1 in every state except IDLE, HOLD, ERR.
REQ-029 i2c_done_i outside a WAIT state SHALL be ignored.

Reset
REQ-030 rst_i=1 at any clock edge, including mid-transaction, SHALL force IDLE, rom_addr_o=0, i2c_send_o=0, i2c_nbytes_o=0, i2c_data_o=0, sample_o=0, sample_valid_o=0, sample_cnt_o=0, busy_o=0, init_done_o=0, err_o=0, all counters 0.

Verification
REQ-031 Defaults, ROM {0x2_00_03_A0, 0x2_00_01_B1}, start_i=1, cont_i=0, responder done 50 cycles after send -> two 2-byte writes 0x03A0,0x01B1, STALL 240000 cycles, 0xB4A0 write, 6-byte read, one sample_valid_o, sample_cnt_o=1, HOLD.
REQ-032 cont_i=1, PERIOD_G=5000 -> CSEND pulses exactly 5000 cycles apart; sample_cnt_o increments once per period; start_i low in PERIOD -> IDLE next cycle.
REQ-033 Responder returns i2c_data_i[47:0]=48'h3333_2222_1111 -> sample_o=48'h3333_2222_1111, ch0=0x1111, ch2=0x3333.
REQ-034 Responder never asserts done, TMO_G=100 -> err_o=1 exactly 100 cycles into the WAIT state; start_i=0 -> IDLE, err_o=0.
REQ-035 rst_i pulsed during RWAIT -> all outputs at reset values next cycle; restart repeats full init sequence from rom_addr_o=0.
REQ-036 i2c_ready_i held low 20 cycles in CSEND -> i2c_send_o stays 0, asserts for one cycle after ready rises.

Source files
------------

// File: rtl/color_poll_seq.sv
// Colour-sensor poller: pushes ROM init writes to an I2C master, then issues
// command/read pairs and publishes each sample, once or at a fixed period.
module color_poll_seq #(
    parameter int unsigned INIT_N_G = 2,
    parameter int unsigned CH_G     = 3,
    parameter int unsigned CH_W_G   = 16,
    parameter int unsigned STALL_G  = 240000,
    parameter int unsigned PERIOD_G = 1000000,
    parameter int unsigned TMO_G    = 4000000,
    parameter logic [15:0] CMD_G    = 16'hB4A0,
    localparam int unsigned ADDR_W  = (INIT_N_G > 0) ? $clog2(INIT_N_G + 1) : 1,
    localparam int unsigned SW      = CH_G * CH_W_G
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              cont_i,
    output logic              i2c_send_o,
    output logic [3:0]        i2c_nbytes_o,
    output logic [71:0]       i2c_data_o,
    input  logic [71:0]       i2c_data_i,
    input  logic              i2c_done_i,
    input  logic              i2c_ready_i,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [31:0]       rom_data_i,
    output logic [SW-1:0]     sample_o,
    output logic              sample_valid_o,
    output logic [15:0]       sample_cnt_o,
    output logic              busy_o,
    output logic              init_done_o,
    output logic              err_o
);

    localparam logic [3:0]  RD_NB   = 4'(SW / 8);
    localparam int unsigned TMO_LIM = (TMO_G > 0) ? TMO_G - 1 : 0;
    localparam int unsigned PER_LIM = (PERIOD_G >= 2) ? PERIOD_G - 2 : 0;

    typedef enum logic [3:0] {
        IDLE, FETCH, ISEND, IWAIT, STALL, CSEND, CWAIT,
        RSEND, RWAIT, PUBLISH, PERIOD, HOLD, ERR
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              send_q, send_d;
    logic [3:0]        nbytes_q, nbytes_d;
    logic [71:0]       data_q, data_d;
    logic [SW-1:0]     sample_q, sample_d;
    logic              valid_q, valid_d;
    logic [15:0]       sample_cnt_q, sample_cnt_d;
    logic              busy_q, busy_d;
    logic              init_done_q, init_done_d;
    logic              err_q, err_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [31:0]       per_cnt_q, per_cnt_d;
    logic              tmo_hit;

    assign tmo_hit = (cnt_q >= TMO_LIM);

    always_comb begin
        state_d      = state_q;
        rom_addr_d   = rom_addr_q;
        send_d       = 1'b0;
        nbytes_d     = nbytes_q;
        data_d       = data_q;
        sample_d     = sample_q;
        valid_d      = 1'b0;
        sample_cnt_d = sample_cnt_q;
        init_done_d  = init_done_q;
        cnt_d        = cnt_q;
        // Cycles elapsed since the last command send; saturates so long reads never wrap.
        per_cnt_d    = (per_cnt_q == '1) ? per_cnt_q : per_cnt_q + 32'd1;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (INIT_N_G == 0 || init_done_q) begin
                        state_d = CSEND;
                    end else begin
                        state_d    = FETCH;
                        rom_addr_d = '0;
                    end
                end
            end
            FETCH: state_d = ISEND;
            ISEND: begin
                if (i2c_ready_i) begin
                    send_d   = 1'b1;
                    nbytes_d = rom_data_i[31:28];
                    data_d   = {48'd0, rom_data_i[23:0]};
                    cnt_d    = '0;
                    state_d  = IWAIT;
                end
            end
            IWAIT: begin
                if (i2c_done_i) begin
                    rom_addr_d = rom_addr_q + ADDR_W'(1);
                    if (32'(rom_addr_q) < INIT_N_G - 1) begin
                        state_d = FETCH;
                    end else begin
                        init_done_d = 1'b1;
                        cnt_d       = '0;
                        state_d     = STALL;
                    end
                end else if (tmo_hit) begin
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            STALL: begin
                if (cnt_q + 32'd1 >= STALL_G) begin
                    cnt_d   = '0;
                    state_d = CSEND;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            CSEND: begin
                if (i2c_ready_i) begin
                    send_d    = 1'b1;
                    nbytes_d  = 4'd2;
                    data_d    = {56'd0, CMD_G};
                    cnt_d     = '0;
                    per_cnt_d = '0;
                    state_d   = CWAIT;
                end
            end
            CWAIT: begin
                if (i2c_done_i)   state_d = RSEND;
                else if (tmo_hit) state_d = ERR;
                else              cnt_d = cnt_q + 32'd1;
            end
            RSEND: begin
                if (i2c_ready_i) begin
                    send_d   = 1'b1;
                    nbytes_d = RD_NB;
                    data_d   = '0;
                    cnt_d    = '0;
                    state_d  = RWAIT;
                end
            end
            RWAIT: begin
                // Sample is captured with done so the valid pulse lines up with PUBLISH.
                if (i2c_done_i) begin
                    sample_d     = i2c_data_i[SW-1:0];
                    valid_d      = 1'b1;
                    sample_cnt_d = sample_cnt_q + 16'd1;
                    state_d      = PUBLISH;
                end else if (tmo_hit) begin
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            PUBLISH: begin
                if (cont_i && start_i) state_d = (per_cnt_q >= PER_LIM) ? CSEND : PERIOD;
                else                   state_d = HOLD;
            end
            PERIOD: begin
                if (!start_i)                  state_d = IDLE;
                else if (per_cnt_q >= PER_LIM) state_d = CSEND;
            end
            HOLD, ERR: if (!start_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        err_d  = (state_d == ERR);
        busy_d = !(state_d inside {IDLE, HOLD, ERR});
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            rom_addr_q   <= '0;
            send_q       <= 1'b0;
            nbytes_q     <= '0;
            data_q       <= '0;
            sample_q     <= '0;
            valid_q      <= 1'b0;
            sample_cnt_q <= '0;
            busy_q       <= 1'b0;
            init_done_q  <= 1'b0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
            per_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            rom_addr_q   <= rom_addr_d;
            send_q       <= send_d;
            nbytes_q     <= nbytes_d;
            data_q       <= data_d;
            sample_q     <= sample_d;
            valid_q      <= valid_d;
            sample_cnt_q <= sample_cnt_d;
            busy_q       <= busy_d;
            init_done_q  <= init_done_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
            per_cnt_q    <= per_cnt_d;
        end
    end

    assign rom_addr_o     = rom_addr_q;
    assign i2c_send_o     = send_q;
    assign i2c_nbytes_o   = nbytes_q;
    assign i2c_data_o     = data_q;
    assign sample_o       = sample_q;
    assign sample_valid_o = valid_q;
    assign sample_cnt_o   = sample_cnt_q;
    assign busy_o         = busy_q;
    assign init_done_o    = init_done_q;
    assign err_o          = err_q;

endmodule

// File: tb/tb_color_poll_seq.sv
// Directed bench for color_poll_seq: init writes, stall, single and periodic
// reads, ready back-pressure, timeout and mid-read reset.
module tb_color_poll_seq;

    localparam int unsigned STALL_P  = 30;
    localparam int unsigned PERIOD_P = 5000;
    localparam int unsigned TMO_P    = 100;
    localparam logic [71:0] RESP     = {24'hABCDEF, 48'h3333_2222_1111};

    logic        clk = 1'b0;
    logic        rst, start, cont, ready, resp_en;
    logic        resp_done = 1'b0, stray_done;
    logic        i2c_done;
    logic        send_o, sample_valid_o, busy_o, init_done_o, err_o;
    logic [3:0]  nbytes_o;
    logic [71:0] data_o;
    logic [1:0]  rom_addr_o;
    logic [31:0] rom_data;
    logic [47:0] sample_o;
    logic [15:0] sample_cnt_o;
    logic [31:0] rom [4];

    int checks = 0, errors = 0, cyc = 0;
    int dly = 0, valid_n = 0, rsend_n = 0, init_cyc = 0, err_cyc = 0;
    logic init_prev = 1'b0, err_prev = 1'b0;
    logic [3:0]  log_nb [$];
    logic [71:0] log_dat [$];
    int          csend_cyc [$];
    int          base;

    always #5 clk = ~clk;
    assign i2c_done = resp_done | stray_done;

    color_poll_seq #(
        .INIT_N_G(2), .CH_G(3), .CH_W_G(16), .STALL_G(STALL_P),
        .PERIOD_G(PERIOD_P), .TMO_G(TMO_P), .CMD_G(16'hB4A0)
    ) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .cont_i(cont),
        .i2c_send_o(send_o), .i2c_nbytes_o(nbytes_o), .i2c_data_o(data_o),
        .i2c_data_i(RESP), .i2c_done_i(i2c_done), .i2c_ready_i(ready),
        .rom_addr_o(rom_addr_o), .rom_data_i(rom_data),
        .sample_o(sample_o), .sample_valid_o(sample_valid_o), .sample_cnt_o(sample_cnt_o),
        .busy_o(busy_o), .init_done_o(init_done_o), .err_o(err_o)
    );

    always @(posedge clk) begin
        cyc++;
        rom_data <= rom[rom_addr_o];
    end

    // Responder: done one cycle wide, 50 cycles after each observed send.
    always @(negedge clk) begin
        if (rst) begin
            dly = 0;
            resp_done = 1'b0;
        end else begin
            resp_done = 1'b0;
            if (dly > 0) begin
                dly--;
                if (dly == 0) resp_done = 1'b1;
            end
            if (send_o && resp_en) dly = 50;
        end
    end

    always @(negedge clk) begin
        if (send_o) begin
            log_nb.push_back(nbytes_o);
            log_dat.push_back(data_o);
            if (nbytes_o == 4'd2 && data_o == 72'hB4A0) csend_cyc.push_back(cyc);
            if (nbytes_o == 4'd6) rsend_n++;
        end
        if (sample_valid_o) valid_n++;
        if (init_done_o && !init_prev) init_cyc = cyc;
        if (err_o && !err_prev) err_cyc = cyc;
        init_prev = init_done_o;
        err_prev  = err_o;
    end

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_send"}, send_o, 0);
        chk({tag, "_nbytes"}, nbytes_o, 0);
        chk({tag, "_data"}, data_o, 0);
        chk({tag, "_sample"}, sample_o, 0);
        chk({tag, "_cnt"}, sample_cnt_o, 0);
        chk({tag, "_valid"}, sample_valid_o, 0);
        chk({tag, "_initdone"}, init_done_o, 0);
        chk({tag, "_err"}, err_o, 0);
        chk({tag, "_addr"}, rom_addr_o, 0);
    endtask

    initial begin
        rom[0] = 32'h2000_03A0;
        rom[1] = 32'h2000_01B1;
        rom[2] = '0;
        rom[3] = '0;
        rst = 1'b1; start = 1'b0; cont = 1'b0; ready = 1'b1; resp_en = 1'b1; stray_done = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset("rst0");
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy_o, 0);

        // Single shot: two init writes, stall, command, 6-byte read.
        start = 1'b1;
        for (int i = 0; i < 2000 && sample_valid_o !== 1'b1; i++) @(negedge clk);
        chk("single_valid", sample_valid_o, 1);
        chk("sample", sample_o, 48'h3333_2222_1111);
        chk("ch0", sample_o[15:0], 16'h1111);
        chk("ch2", sample_o[47:32], 16'h3333);
        chk("cnt1", sample_cnt_o, 1);
        repeat (4) @(negedge clk);
        chk("nsends", log_nb.size(), 4);
        chk("w0_nb", log_nb[0], 2);
        chk("w0_dat", log_dat[0], 72'h03A0);
        chk("w1_nb", log_nb[1], 2);
        chk("w1_dat", log_dat[1], 72'h01B1);
        chk("cmd_nb", log_nb[2], 2);
        chk("cmd_dat", log_dat[2], 72'hB4A0);
        chk("rd_nb", log_nb[3], 6);
        chk("rd_dat", log_dat[3], 0);
        chk("stall_len", csend_cyc[0] - init_cyc, STALL_P + 1);
        chk("hold_busy", busy_o, 0);
        chk("valid_once", valid_n, 1);
        chk("init_done", init_done_o, 1);

        // Stray done while holding must not disturb anything.
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("stray_busy", busy_o, 0);
        chk("stray_cnt", sample_cnt_o, 1);
        chk("stray_valid", valid_n, 1);
        chk("stray_nsends", log_nb.size(), 4);

        // Back-pressure: ready low in CSEND holds send off.
        start = 1'b0;
        repeat (2) @(negedge clk);
        ready = 1'b0; cont = 1'b1; start = 1'b1;
        repeat (20) @(negedge clk);
        chk("rdy_nosend", log_nb.size(), 4);
        chk("rdy_send_lo", send_o, 0);
        chk("rdy_busy", busy_o, 1);
        ready = 1'b1;
        @(negedge clk);
        chk("rdy_send_hi", send_o, 1);
        chk("rdy_send_cmd", data_o, 72'hB4A0);
        @(negedge clk);
        chk("rdy_send_pulse", send_o, 0);

        // Continuous polling at PERIOD_P.
        for (int i = 0; i < 6000 && csend_cyc.size() < 3; i++) @(negedge clk);
        for (int i = 0; i < 6000 && csend_cyc.size() < 4; i++) @(negedge clk);
        chk("ncsend", csend_cyc.size(), 4);
        chk("period1", csend_cyc[2] - csend_cyc[1], PERIOD_P);
        chk("period2", csend_cyc[3] - csend_cyc[2], PERIOD_P);
        for (int i = 0; i < 500 && sample_valid_o !== 1'b1; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("cnt4", sample_cnt_o, 4);
        chk("period_busy", busy_o, 1);
        start = 1'b0;
        @(negedge clk);
        chk("period_abort", busy_o, 0);

        // Timeout: responder silent.
        resp_en = 1'b0; cont = 1'b0;
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < 400 && err_o !== 1'b1; i++) @(negedge clk);
        chk("tmo_err", err_o, 1);
        @(negedge clk);
        chk("tmo_len", err_cyc - csend_cyc[4], TMO_P);
        chk("tmo_sample", sample_o, 48'h3333_2222_1111);
        chk("tmo_busy", busy_o, 0);
        start = 1'b0;
        @(negedge clk);
        chk("tmo_clear", err_o, 0);
        chk("tmo_idle", busy_o, 0);

        // Reset in the middle of the read, then full re-init.
        resp_en = 1'b1;
        base = rsend_n;
        start = 1'b1;
        for (int i = 0; i < 400 && rsend_n <= base; i++) @(negedge clk);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_reset("rst1");
        base = log_nb.size();
        rst = 1'b0;
        for (int i = 0; i < 100 && log_nb.size() <= base; i++) @(negedge clk);
        @(negedge clk);
        chk("reinit_nb", log_nb[base], 2);
        chk("reinit_dat", log_dat[base], 72'h03A0);
        for (int i = 0; i < 1000 && sample_valid_o !== 1'b1; i++) @(negedge clk);
        chk("reinit_valid", sample_valid_o, 1);
        chk("reinit_cnt", sample_cnt_o, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
